// File: rtl/fsb_pcim_pkg.sv
// rtl/fsb_pcim_pkg.sv - shared constants and FSM state type for the PCIM->FSB reader
package fsb_pcim_pkg;

   localparam logic [7:0] REG_BASE_LO    = 8'h00;
   localparam logic [7:0] REG_BASE_HI    = 8'h04;
   localparam logic [7:0] REG_RING_BEATS = 8'h08;
   localparam logic [7:0] REG_HEAD       = 8'h0C;
   localparam logic [7:0] REG_TAIL       = 8'h10;
   localparam logic [7:0] REG_CTRL       = 8'h14;
   localparam logic [7:0] REG_STATUS     = 8'h18;
   localparam logic [7:0] REG_PKT_CNT    = 8'h1C;

   localparam int SLOT_W       = 128;
   localparam int SLOT_VLD_BIT = 127;

   localparam logic [2:0] AXI_SIZE_64B = 3'h6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AR,
      ST_RD,
      ST_DRAIN
   } fsm_state_e;

endpackage

// File: rtl/fsb_beat_unpack.sv
// rtl/fsb_beat_unpack.sv - holds one captured PCIM beat and emits its valid slots as FSB packets
module fsb_beat_unpack
   import fsb_pcim_pkg::*;
#(
   parameter int FSB_WIDTH  = 80,
   parameter int DATA_WIDTH = 512
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_beat,
   input  logic                  i_active,
   input  logic                  i_yumi,
   output logic                  o_v,
   output logic [FSB_WIDTH-1:0]  o_data,
   output logic                  o_done
);

   localparam int SLOTS = DATA_WIDTH / SLOT_W;
   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

   logic [SLOTS-1:0]     r_vld;
   logic [FSB_WIDTH-1:0] r_pkt [SLOTS];
   logic [IDX_W-1:0]     r_idx;
   logic                 w_cur_vld;
   logic                 w_step;
   logic                 w_unused_beat;

   // only the slot-valid bit and the low FSB_WIDTH bits of each slot are kept
   assign w_unused_beat = ^i_beat;

   assign w_cur_vld = r_vld[r_idx];
   // an invalid slot advances on its own; a valid one waits for the consumer
   assign w_step    = i_active && (!w_cur_vld || i_yumi);
   assign o_done    = w_step && (r_idx == LAST_IDX);
   assign o_v       = i_active && w_cur_vld;
   assign o_data    = o_v ? r_pkt[r_idx] : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld <= '0;
         r_idx <= '0;
         for (int k = 0; k < SLOTS; k++) begin
            r_pkt[k] <= '0;
         end
      end else if (i_load) begin
         r_idx <= '0;
         for (int k = 0; k < SLOTS; k++) begin
            r_vld[k] <= i_beat[k*SLOT_W + SLOT_VLD_BIT];
            r_pkt[k] <= i_beat[k*SLOT_W +: FSB_WIDTH];
         end
      end else if (w_step) begin
         r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
   end

endmodule

// File: rtl/m_axi4_fsb_reader.sv
// rtl/m_axi4_fsb_reader.sv - AXI4 read master draining a host ring buffer into FSB packets
// Optional FSB_RD_PKT_CNT_EN adds a 32-bit consumed-packet counter at 0x1C.
module m_axi4_fsb_reader
   import fsb_pcim_pkg::*;
#(
   parameter int FSB_WIDTH  = 80,
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 6,
   parameter int PTR_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  resetn_i,
   input  logic                  cfg_wr_i,
   input  logic                  cfg_rd_i,
   input  logic [7:0]            cfg_addr_i,
   input  logic [31:0]           cfg_wdata_i,
   output logic [31:0]           cfg_rdata_o,
   output logic                  cfg_ack_o,
   output logic [ID_WIDTH-1:0]   arid_o,
   output logic [63:0]           araddr_o,
   output logic [7:0]            arlen_o,
   output logic [2:0]            arsize_o,
   output logic                  arvalid_o,
   input  logic                  arready_i,
   input  logic [ID_WIDTH-1:0]   rid_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic [1:0]            rresp_i,
   input  logic                  rlast_i,
   input  logic                  rvalid_i,
   output logic                  rready_o,
   output logic                  fsb_v_o,
   output logic [FSB_WIDTH-1:0]  fsb_data_o,
   input  logic                  fsb_yumi_i
);

   fsm_state_e           r_state;
   fsm_state_e           w_state_next;
   logic [63:6]          r_base;
   logic [PTR_WIDTH-1:0] r_ring;
   logic [PTR_WIDTH-1:0] r_head;
   logic [PTR_WIDTH-1:0] r_tail;
   logic                 r_en;
   logic                 r_err;
   logic                 r_cfg_ack;
   logic [31:0]          r_cfg_rdata;
   logic [31:0]          w_rdata;
   logic [31:0]          w_pkt_cnt;
   logic [63:0]          w_araddr;
   logic [PTR_WIDTH-1:0] w_tail_next;
   logic                 w_cfg_open;
   logic                 w_load;
   logic                 w_err;
   logic                 w_done;
   logic                 w_unused_r;

   // single-beat bursts: rlast is always set and the ID is always zero
   assign w_unused_r = ^{rid_i, rlast_i};

   assign arid_o      = '0;
   assign arlen_o     = 8'h00;
   assign arsize_o    = AXI_SIZE_64B;
   assign w_araddr    = {r_base, 6'b0} + (64'(r_tail) << 6);
   assign araddr_o    = (r_state == ST_AR) ? w_araddr : '0;
   assign w_tail_next = (r_tail == r_ring - 1'b1) ? '0 : r_tail + 1'b1;
   assign w_cfg_open  = !r_en && (r_state == ST_IDLE);
   assign cfg_ack_o   = r_cfg_ack;
   assign cfg_rdata_o = r_cfg_rdata;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      arvalid_o    = 1'b0;
      rready_o     = 1'b0;
      w_load       = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_en && (r_ring != '0) && (r_head != r_tail)) begin
               w_state_next = ST_AR;
            end
         end
         ST_AR: begin
            arvalid_o = 1'b1;
            if (arready_i) begin
               w_state_next = ST_RD;
            end
         end
         ST_RD: begin
            rready_o = 1'b1;
            if (rvalid_i) begin
               if (rresp_i != 2'b00) begin
                  w_err        = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_load       = 1'b1;
                  w_state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (w_done) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   fsb_beat_unpack #(
      .FSB_WIDTH  (FSB_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_unpack (
      .i_clk    (clk_i),
      .i_rst_n  (resetn_i),
      .i_load   (w_load),
      .i_beat   (rdata_i),
      .i_active (r_state == ST_DRAIN),
      .i_yumi   (fsb_yumi_i),
      .o_v      (fsb_v_o),
      .o_data   (fsb_data_o),
      .o_done   (w_done)
   );

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_base <= '0;
         r_ring <= '0;
         r_head <= '0;
         r_tail <= '0;
         r_en   <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (cfg_wr_i) begin
            case (cfg_addr_i)
               REG_BASE_LO: if (w_cfg_open) r_base[31:6] <= cfg_wdata_i[31:6];
               REG_BASE_HI: if (w_cfg_open) r_base[63:32] <= cfg_wdata_i;
               REG_RING_BEATS: if (w_cfg_open) r_ring <= cfg_wdata_i[PTR_WIDTH-1:0];
               REG_HEAD: if (cfg_wdata_i < 32'(r_ring)) r_head <= cfg_wdata_i[PTR_WIDTH-1:0];
               REG_CTRL: r_en <= cfg_wdata_i[0];
               REG_STATUS: if (cfg_wdata_i[0]) r_err <= 1'b0;
               default: ;
            endcase
         end
         // resizing the ring restarts consumption from its first beat
         if (cfg_wr_i && (cfg_addr_i == REG_RING_BEATS) && w_cfg_open) begin
            r_tail <= '0;
         end else if (w_done) begin
            r_tail <= w_tail_next;
         end
         // a bad response wins over a same-cycle CTRL write or W1C
         if (w_err) begin
            r_err <= 1'b1;
            r_en  <= 1'b0;
         end
      end
   end

`ifdef FSB_RD_PKT_CNT_EN
   logic [31:0] r_pkt_cnt;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_pkt_cnt <= '0;
      end else if (cfg_wr_i && (cfg_addr_i == REG_PKT_CNT)) begin
         r_pkt_cnt <= '0;
      end else if (fsb_yumi_i) begin
         r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
   end

   assign w_pkt_cnt = r_pkt_cnt;
`else
   assign w_pkt_cnt = '0;
`endif

   always_comb begin
      w_rdata = '0;
      case (cfg_addr_i)
         REG_BASE_LO:    w_rdata = {r_base[31:6], 6'b0};
         REG_BASE_HI:    w_rdata = r_base[63:32];
         REG_RING_BEATS: w_rdata = 32'(r_ring);
         REG_HEAD:       w_rdata = 32'(r_head);
         REG_TAIL:       w_rdata = 32'(r_tail);
         REG_CTRL:       w_rdata = {31'b0, r_en};
         REG_STATUS:     w_rdata = {30'b0, (r_state == ST_IDLE), r_err};
         REG_PKT_CNT:    w_rdata = w_pkt_cnt;
         default:        w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_cfg_ack   <= 1'b0;
         r_cfg_rdata <= '0;
      end else begin
         r_cfg_ack   <= cfg_wr_i || cfg_rd_i;
         r_cfg_rdata <= cfg_rd_i ? w_rdata : '0;
      end
   end

endmodule
